// File: rtl/dl_fec_pkg.sv
// rtl/dl_fec_pkg.sv - shared state type and CRC/length helpers for the FEC frame encoder
package dl_fec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CRC,
    ST_PAR,
    ST_HOLD
  } state_t;

  localparam int CRC_MAX_W = 32;

  // One MSB-first CRC bit update; bits at and above width are cleared.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 din,
    input logic [CRC_MAX_W-1:0] poly,
    input int                   width
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] nxt;
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] top;
    mask = '0;
    top  = '0;
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i < width) mask[i] = 1'b1;
      if (i == width - 1) top[i] = 1'b1;
    end
    fb  = (|(crc & top)) ^ din;
    nxt = (crc << 1) ^ (fb ? poly : '0);
    return nxt & mask;
  endfunction

  function automatic logic len_is_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/dl_fec_crc_serial.sv
// rtl/dl_fec_crc_serial.sv - sequential CRC over the first len bytes, BITS_PER_CYCLE bits per clock
// done is combinational on the final step so the caller can leave its CRC state on that edge.
module dl_fec_crc_serial
  import dl_fec_pkg::*;
#(
  parameter int               NUM_BYTES      = 7,
  parameter int               BYTE_W         = 8,
  parameter int               CRC_W          = 8,
  parameter logic [CRC_W-1:0] CRC_POLY       = 8'h07,
  parameter logic [CRC_W-1:0] CRC_SEED       = 8'h00,
  parameter int               BITS_PER_CYCLE = 8,
  parameter int               LEN_W          = $clog2(NUM_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        step,
  input  logic [LEN_W-1:0]            len,
  input  logic [NUM_BYTES*BYTE_W-1:0] data,
  output logic [CRC_W-1:0]            crc,
  output logic                        done
);

  localparam int CHUNKS     = BYTE_W / BITS_PER_CYCLE;
  localparam int BYTE_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CHUNK_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [BYTE_IDX_W-1:0]     byte_idx;
  logic [CHUNK_W-1:0]        chunk_idx;
  logic [BITS_PER_CYCLE-1:0] chunk_bits;
  logic [CRC_W-1:0]          crc_next;
  logic [CRC_MAX_W-1:0]      step_res;
  logic                      last_chunk;
  logic                      last_byte;

  assign last_chunk = (int'(chunk_idx) == CHUNKS - 1);
  assign last_byte  = (int'(byte_idx) == int'(len) - 1);
  assign done       = step && last_chunk && last_byte;

  // Chunk c of a byte covers its bits from the MSB downward.
  always_comb begin
    chunk_bits = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        if (int'(byte_idx) == b && int'(chunk_idx) == c)
          chunk_bits = data[b*BYTE_W + BYTE_W - (c+1)*BITS_PER_CYCLE +: BITS_PER_CYCLE];
      end
    end
    crc_next = crc;
    step_res = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      step_res = crc_step(CRC_MAX_W'(crc_next), chunk_bits[i], CRC_MAX_W'(CRC_POLY), CRC_W);
      crc_next = step_res[CRC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc       <= '0;
      byte_idx  <= '0;
      chunk_idx <= '0;
    end else if (load) begin
      crc       <= CRC_SEED;
      byte_idx  <= '0;
      chunk_idx <= '0;
    end else if (step) begin
      crc <= crc_next;
      if (last_chunk) begin
        chunk_idx <= '0;
        byte_idx  <= byte_idx + BYTE_IDX_W'(1);
      end else begin
        chunk_idx <= chunk_idx + CHUNK_W'(1);
      end
    end
  end

endmodule

// File: rtl/dl_fec_frame_enc.sv
// rtl/dl_fec_frame_enc.sv - runtime-length frame CRC plus 2-D parity block with valid/ready result hold
// Optional DL_FEC_ERR_INJ_EN: inj_mask corrupts crc_out only; parity always uses the true CRC.
module dl_fec_frame_enc
  import dl_fec_pkg::*;
#(
  parameter int               NUM_BYTES      = 7,
  parameter int               BYTE_W         = 8,
  parameter int               CRC_W          = 8,
  parameter logic [CRC_W-1:0] CRC_POLY       = 8'h07,
  parameter logic [CRC_W-1:0] CRC_SEED       = 8'h00,
  parameter int               BITS_PER_CYCLE = 8,
  localparam int              LEN_W          = $clog2(NUM_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            len,
  input  logic [NUM_BYTES*BYTE_W-1:0] data_in,
`ifdef DL_FEC_ERR_INJ_EN
  input  logic [CRC_W-1:0]            inj_mask,
`endif
  output logic                        busy,
  output logic                        err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CRC_W-1:0]            crc_out,
  output logic [NUM_BYTES:0]          row_p,
  output logic [BYTE_W-1:0]           col_p
);

  state_t                      state;
  logic [NUM_BYTES*BYTE_W-1:0] cap_data;
  logic [LEN_W-1:0]            cap_len;
  logic [CRC_W-1:0]            crc;
  logic [CRC_W-1:0]            crc_final;
  logic                        crc_done;
  logic                        len_ok;
  logic                        accept;
  logic                        load;
  logic [NUM_BYTES:0]          row_p_next;
  logic [BYTE_W-1:0]           col_p_next;

  assign len_ok = len_is_legal(int'(len), NUM_BYTES);
  assign accept = start && ((state == ST_IDLE) || (state == ST_HOLD && out_ready));
  assign load   = accept && len_ok;

  dl_fec_crc_serial #(
    .NUM_BYTES      (NUM_BYTES),
    .BYTE_W         (BYTE_W),
    .CRC_W          (CRC_W),
    .CRC_POLY       (CRC_POLY),
    .CRC_SEED       (CRC_SEED),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .LEN_W          (LEN_W)
  ) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (state == ST_CRC),
    .len   (cap_len),
    .data  (cap_data),
    .crc   (crc),
    .done  (crc_done)
  );

`ifdef DL_FEC_ERR_INJ_EN
  logic [CRC_W-1:0] inj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    inj_q <= '0;
    else if (load) inj_q <= inj_mask;
  end

  assign crc_final = crc ^ inj_q;
`else
  assign crc_final = crc;
`endif

  // Rows at or beyond the captured length contribute nothing; the CRC is the last row.
  always_comb begin
    row_p_next            = '0;
    row_p_next[NUM_BYTES] = ^crc;
    col_p_next            = crc;
    for (int r = 0; r < NUM_BYTES; r++) begin
      if (r < int'(cap_len)) begin
        row_p_next[r] = ^cap_data[r*BYTE_W +: BYTE_W];
        col_p_next    = col_p_next ^ cap_data[r*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      crc_out   <= '0;
      row_p     <= '0;
      col_p     <= '0;
      cap_data  <= '0;
      cap_len   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_CRC: begin
          if (crc_done) state <= ST_PAR;
        end
        ST_PAR: begin
          state     <= ST_HOLD;
          out_valid <= 1'b1;
          crc_out   <= crc_final;
          row_p     <= row_p_next;
          col_p     <= col_p_next;
        end
        default: begin
          if (state == ST_HOLD && out_ready) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
          // A back-to-back start overrides the return to IDLE above.
          if (accept) begin
            if (len_ok) begin
              cap_data <= data_in;
              cap_len  <= len;
              state    <= ST_CRC;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dl_fec_frame_enc.sv
// tb/tb_dl_fec_frame_enc.sv - randomized self-checking bench for dl_fec_frame_enc
module tb_dl_fec_frame_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, out_ready, busy, err, out_valid;
  logic [2:0]  len;
  logic [55:0] data_in;
  logic [7:0]  crc_out, row_p, col_p;

  logic        start9, ready9, busy9, err9, valid9;
  logic [3:0]  len9;
  logic [71:0] data9;
  logic [7:0]  crc9, col9;
  logic [9:0]  row9;

`ifdef DL_FEC_ERR_INJ_EN
  logic [7:0] inj_mask, inj9;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  dl_fec_frame_enc u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .data_in   (data_in),
`ifdef DL_FEC_ERR_INJ_EN
    .inj_mask  (inj_mask),
`endif
    .busy      (busy),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .crc_out   (crc_out),
    .row_p     (row_p),
    .col_p     (col_p)
  );

  dl_fec_frame_enc #(.NUM_BYTES(9), .BITS_PER_CYCLE(1)) u_dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start9),
    .len       (len9),
    .data_in   (data9),
`ifdef DL_FEC_ERR_INJ_EN
    .inj_mask  (inj9),
`endif
    .busy      (busy9),
    .err       (err9),
    .out_valid (valid9),
    .out_ready (ready9),
    .crc_out   (crc9),
    .row_p     (row9),
    .col_p     (col9)
  );

  // CRC as the remainder of M(x)*x^8 modulo x^8+x^2+x+1 (zero seed, no reflection).
  function automatic logic [7:0] ref_crc(input logic [71:0] d, input int l);
    logic [8:0] rem;
    bit         q[$];
    rem = '0;
    for (int b = 0; b < l; b++)
      for (int k = 7; k >= 0; k--) q.push_back(d[b*8+k]);
    repeat (8) q.push_back(1'b0);
    foreach (q[i]) begin
      rem = {rem[7:0], q[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  function automatic logic [9:0] ref_row(input logic [71:0] d, input int l, input int nb, input logic [7:0] c);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < l; i++) r[i] = ($countones(d[i*8 +: 8]) % 2) == 1;
    r[nb] = ($countones(c) % 2) == 1;
    return r;
  endfunction

  function automatic logic [7:0] ref_col(input logic [71:0] d, input int l, input logic [7:0] c);
    logic [7:0] p;
    int         n;
    for (int j = 0; j < 8; j++) begin
      n = int'(c[j]);
      for (int i = 0; i < l; i++) n = n + int'(d[i*8+j]);
      p[j] = (n % 2) == 1;
    end
    return p;
  endfunction

  task automatic frame(input int l, input logic [55:0] d, output int cycles);
    @(negedge clk);
    start = 1'b1; len = 3'(l); data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic frame9(input int l, input logic [71:0] d, output int cycles);
    @(negedge clk);
    start9 = 1'b1; len9 = 4'(l); data9 = d;
    @(posedge clk); #1;
    start9 = 1'b0;
    cycles = 0;
    while (!valid9 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; len = 3'd1; data_in = '0; out_ready = 1'b1;
    start9 = 1'b0; len9 = 4'd1; data9 = '0; ready9 = 1'b1;
`ifdef DL_FEC_ERR_INJ_EN
    inj_mask = '0; inj9 = '0;
`endif
    repeat (3) @(negedge clk);
    tests_run++; if ({busy, err, out_valid, crc_out, row_p, col_p} !== 27'h0) begin tests_failed++; $display("FAIL reset_dut: got %h want 0", {busy, err, out_valid, crc_out, row_p, col_p}); end
    tests_run++; if ({busy9, err9, valid9, crc9, row9, col9} !== 29'h0) begin tests_failed++; $display("FAIL reset_dut9: got %h want 0", {busy9, err9, valid9, crc9, row9, col9}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    int cyc;
    frame(1, 56'h01, cyc);
    tests_run++; if (cyc != 2) begin tests_failed++; $display("FAIL single_latency: got %0d want 2", cyc); end
    tests_run++; if (crc_out !== 8'h07) begin tests_failed++; $display("FAIL single_crc: got %h want 07", crc_out); end
    tests_run++; if (row_p !== 8'h81) begin tests_failed++; $display("FAIL single_row: got %h want 81", row_p); end
    tests_run++; if (col_p !== 8'h06) begin tests_failed++; $display("FAIL single_col: got %h want 06", col_p); end
    @(posedge clk); #1;
    tests_run++; if ({busy, out_valid} !== 2'b00) begin tests_failed++; $display("FAIL single_release: busy/valid got %b want 00", {busy, out_valid}); end
  endtask

  task automatic test_random_frames;
    int          cyc, l;
    logic [63:0] r;
    logic [55:0] d;
    logic [7:0]  ec;
    logic [9:0]  er;
    for (int it = 0; it < 20; it++) begin
      l = $urandom_range(1, 7);
      r = {$urandom, $urandom};
      d = r[55:0];
      ec = ref_crc({16'h0, d}, l);
      er = ref_row({16'h0, d}, l, 7, ec);
      frame(l, d, cyc);
      tests_run++; if (cyc != l + 1) begin tests_failed++; $display("FAIL rand_latency len=%0d: got %0d want %0d", l, cyc, l + 1); end
      tests_run++; if (crc_out !== ec) begin tests_failed++; $display("FAIL rand_crc len=%0d: got %h want %h", l, crc_out, ec); end
      tests_run++; if (row_p !== er[7:0]) begin tests_failed++; $display("FAIL rand_row len=%0d: got %h want %h", l, row_p, er[7:0]); end
      tests_run++; if (col_p !== ref_col({16'h0, d}, l, ec)) begin tests_failed++; $display("FAIL rand_col len=%0d: got %h want %h", l, col_p, ref_col({16'h0, d}, l, ec)); end
      @(posedge clk); #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rand_busy_after: got %b want 0", busy); end
    end
  endtask

  task automatic test_check_string;
    int          cyc;
    logic [71:0] d;
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'h31 + 8'(i);
    frame9(9, d, cyc);
    tests_run++; if (cyc != 73) begin tests_failed++; $display("FAIL str_latency: got %0d want 73", cyc); end
    tests_run++; if (crc9 !== 8'hF4) begin tests_failed++; $display("FAIL str_crc: got %h want f4", crc9); end
    tests_run++; if (row9 !== ref_row(d, 9, 9, 8'hF4)) begin tests_failed++; $display("FAIL str_row: got %h want %h", row9, ref_row(d, 9, 9, 8'hF4)); end
    tests_run++; if (col9 !== ref_col(d, 9, 8'hF4)) begin tests_failed++; $display("FAIL str_col: got %h want %h", col9, ref_col(d, 9, 8'hF4)); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int          cyc;
    logic [71:0] d;
    d = {8'h5a, $urandom, $urandom};
    frame9(9, d, cyc);
    @(posedge clk); #1;
    @(negedge clk);
    start9 = 1'b1; len9 = 4'd9; data9 = d;
    @(posedge clk); #1;
    start9 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests_run++; if (busy9 !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %b want 1", busy9); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if ({busy9, err9, valid9, crc9, row9, col9} !== 29'h0) begin tests_failed++; $display("FAIL mid_reset_outputs: got %h want 0", {busy9, err9, valid9, crc9, row9, col9}); end
    @(negedge clk);
    rst_n = 1'b1;
    frame9(1, 72'h01, cyc);
    tests_run++; if (cyc != 9) begin tests_failed++; $display("FAIL mid_after_latency: got %0d want 9", cyc); end
    tests_run++; if (crc9 !== 8'h07) begin tests_failed++; $display("FAIL mid_after_crc: got %h want 07", crc9); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_len;
    @(negedge clk);
    start = 1'b1; len = 3'd0; data_in = {$urandom, 24'h0};
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++; if ({err, busy, out_valid} !== 3'b100) begin tests_failed++; $display("FAIL illegal0_pulse: err/busy/valid got %b want 100", {err, busy, out_valid}); end
    @(posedge clk); #1;
    tests_run++; if ({err, busy, out_valid} !== 3'b000) begin tests_failed++; $display("FAIL illegal0_clear: err/busy/valid got %b want 000", {err, busy, out_valid}); end
    @(negedge clk);
    start9 = 1'b1; len9 = 4'($urandom_range(10, 15));
    @(posedge clk); #1;
    start9 = 1'b0;
    tests_run++; if ({err9, busy9, valid9} !== 3'b100) begin tests_failed++; $display("FAIL illegal_big_pulse: err/busy/valid got %b want 100", {err9, busy9, valid9}); end
    @(posedge clk); #1;
    tests_run++; if ({err9, busy9, valid9} !== 3'b000) begin tests_failed++; $display("FAIL illegal_big_clear: err/busy/valid got %b want 000", {err9, busy9, valid9}); end
  endtask

  task automatic test_back_to_back;
    int          cyc;
    logic [63:0] r;
    logic [55:0] d;
    logic [7:0]  ec, ecol;
    logic [9:0]  er;
    r = {$urandom, $urandom};
    d = r[55:0];
    ec = ref_crc({16'h0, d}, 3);
    er = ref_row({16'h0, d}, 3, 7, ec);
    ecol = ref_col({16'h0, d}, 3, ec);
    out_ready = 1'b0;
    frame(3, d, cyc);
    tests_run++; if (cyc != 4) begin tests_failed++; $display("FAIL bp_latency: got %0d want 4", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1; len = 3'($urandom_range(1, 7)); data_in = {$urandom, 24'h0};
      @(posedge clk); #1;
      tests_run++; if ({out_valid, busy, err, crc_out, row_p, col_p} !== {3'b110, ec, er[7:0], ecol}) begin tests_failed++; $display("FAIL bp_hold_cycle%0d: got %h want %h", i, {out_valid, busy, err, crc_out, row_p, col_p}, {3'b110, ec, er[7:0], ecol}); end
    end
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; len = 3'd1;
    r = {$urandom, $urandom};
    data_in = {r[55:8], 8'h00};
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++; if ({out_valid, busy} !== 2'b01) begin tests_failed++; $display("FAIL b2b_no_idle: valid/busy got %b want 01", {out_valid, busy}); end
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++; if (cyc != 2) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 2", cyc); end
    tests_run++; if ({crc_out, row_p, col_p} !== 24'h0) begin tests_failed++; $display("FAIL b2b_result: got %h want 0", {crc_out, row_p, col_p}); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    frame(1, 56'h01, cyc);
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; len = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++; if ({err, busy, out_valid} !== 3'b100) begin tests_failed++; $display("FAIL b2b_illegal: err/busy/valid got %b want 100", {err, busy, out_valid}); end
    tests_run++; if (crc_out !== 8'h07) begin tests_failed++; $display("FAIL b2b_result_kept: got %h want 07", crc_out); end
  endtask

`ifdef DL_FEC_ERR_INJ_EN
  task automatic test_err_inj;
    int cyc;
    inj_mask = 8'h80;
    frame(1, 56'h01, cyc);
    inj_mask = 8'h00;
    tests_run++; if (crc_out !== 8'h87) begin tests_failed++; $display("FAIL inj_crc: got %h want 87", crc_out); end
    tests_run++; if (row_p !== 8'h81) begin tests_failed++; $display("FAIL inj_row: got %h want 81", row_p); end
    tests_run++; if (col_p !== 8'h06) begin tests_failed++; $display("FAIL inj_col: got %h want 06", col_p); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_byte();
    test_random_frames();
    test_check_string();
    test_reset_mid();
    test_illegal_len();
    test_back_to_back();
`ifdef DL_FEC_ERR_INJ_EN
    test_err_inj();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
